kc87_ps2_matrix: RTL and testbench
==================================

// Module: kc87_ps2_matrix
// PURPOSE
//  Converts hps_io ps2_key events into the KC87 8x8 keyboard matrix read by the kc87 core's keyboard PIO.
//  Sits between hps_io (.ps2_key) and the kc87 instance in the clk_sys domain.
//  Queues events and holds each one long enough for the Z80 scan routine to see it.
//  Synthesises KC shift for PC keys whose shift state differs.
// PARAMETERS
//  HOLD_CYCLES  500000  min clk cycles a matrix change stays stable before the next event is applied
//  FIFO_DEPTH   4       event queue depth (power of 2, >=2)
// PORTS
//  clk        in   1   system clock (clk_sys)
//  reset      in   1   asynchronous, active-high; clears all state
//  ps2_key    in   11  [10]=toggle per event, [9]=pressed, [8]=E0-extended, [7:0]=set-2 scancode
//  col_sel_n  in   8   PIO column drive, active low; several columns may be low at once
//  row_n      out  8   matrix rows, active low; combinational from registered matrix
//  kbd_busy   out  1   high while FSM is not IDLE or FIFO is non-empty
//  kbd_ovf    out  1   sticky: an event was dropped on a full FIFO; cleared only by reset
// BEHAVIOUR
//  Reset values: matrix=0, row_n=8'hFF, kbd_busy=0, kbd_ovf=0, toggle_q=0, FIFO empty, FSM IDLE.
//  Capture: toggle_q<=ps2_key[10] every cycle.
//   ps2_key[10]!=toggle_q pushes {pressed,ext,code} (10 bit).
//   If full: drop, set kbd_ovf.
//   Push and pop in the same cycle are legal on a full FIFO; the pop frees the slot.
//  FSM: IDLE -> POP (FIFO non-empty; pop 1 entry) -> DECODE (registered lookup, 1 cycle) -> APPLY -> HOLD -> IDLE.
//   DECODE, unmapped code: back to IDLE, no matrix change.
//   DECODE, L/R shift (12h/59h): update pc_shl/pc_shr -> HOLD.
//   APPLY, press: set matrix[col][row]; if the entry has shift_force, set fshift and record the key as fkey.
//   APPLY, release: clear the bit; if the key == fkey, clear fshift.
//   APPLY, no-op (press of set bit / release of clear bit, e.g. typematic repeat): skip HOLD -> IDLE.
//   HOLD: counter loads HOLD_CYCLES-1 and counts to 0, then IDLE.
//  Shift bit: matrix[KC_SHIFT_COL][KC_SHIFT_ROW] = (pc_shl|pc_shr) ^ fshift.
//   fshift inverts the host shift, so ':' (PC shift+;) becomes unshifted KC ':' and vice versa.
//  Read: row_n = ~(OR of matrix[c] over every c with col_sel_n[c]==0). col_sel_n=8'hFF gives row_n=8'hFF.
//  Event->row_n latency for an idle block: 4 clk after the toggle edge.
//  Async reset mid-HOLD or mid-queue discards everything, with no glitch beyond reset release.
// CONFIGURATION
//  Macro KC87_KBD_GHOST_EN.
//  Defined: real-matrix ghosting, one level.
//   Effective column set = selected columns plus any column sharing a pressed row with a selected column.
//   row_n is computed over that set.
//  Undefined: no ghosting; the pure OR described above.
// STRUCTURE
//  Package kc87_kbd_pkg:
//   kbd_evt_t {pressed,ext,code}.
//   kbd_map_t {valid,col[2:0],row[2:0],shift_force}.
//   KC_SHIFT_COL=0, KC_SHIFT_ROW=7.
//   Function kbd_lookup(ext,code) returning kbd_map_t (full scancode table).
//  Sub-module kc87_kbd_fifo: sync FIFO, FIFO_DEPTH, async active-high reset, full/empty/push/pop.
//  Top: capture, FSM, hold counter, matrix, read/ghost logic.
// TESTING
//  1. Reset, idle -> row_n=FF, kbd_busy=0, kbd_ovf=0; ps2_key toggles during reset are ignored.
//  2. Press 'A' (1Ch): toggle, pressed=1; col_sel_n=~(1<<mapA.col) -> row_n bit mapA.row=0 after 4 clk.
//     Release -> bit back to 1 after that event's HOLD.
//  3. HOLD_CYCLES=16: press then release 'A' on consecutive cycles -> key seen low for >=16 clk.
//     kbd_busy stays high until the release HOLD ends.
//  4. FIFO_DEPTH=4: toggle 6 events back-to-back -> kbd_ovf=1; 5 events applied in order, the 6th lost.
//  5. Shift: press 12h then 4Ch (':') -> shift bit equals (1^fshift), matching the map.
//     Release 4Ch -> fshift cleared; shift bit follows pc_shl only.
//  6. Ghost (macro on): press (c0,r0),(c1,r0),(c1,r1); select c0 only -> row_n=FC. Macro off -> FE.

Source files
------------

// File: rtl/kc87_kbd_pkg.sv
// KC87 keyboard types, constants and the PS/2 set-2 to KC87 matrix table.
// Shared by the FIFO and kc87_ps2_matrix.
package kc87_kbd_pkg;

   typedef struct packed {
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } kbd_evt_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] col;
      logic [2:0] row;
      logic       shift_force;
   } kbd_map_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_DECODE,
      S_APPLY,
      S_HOLD
   } kbd_state_t;

   localparam int KC_SHIFT_COL = 0;
   localparam int KC_SHIFT_ROW = 7;

   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   // cr is {col,row} written as two octal digits
   function automatic kbd_map_t km(input logic [5:0] cr,
                                   input logic sf);
      return kbd_map_t'({1'b1, cr, sf});
   endfunction

   function automatic kbd_map_t kbd_lookup(input logic ext,
                                           input logic [7:0] code);
      kbd_map_t m;
      m = '0;
      if (ext) begin
         case (code)
            8'h75:   m = km(6'o60, 1'b0);
            8'h72:   m = km(6'o61, 1'b0);
            8'h6B:   m = km(6'o62, 1'b0);
            8'h74:   m = km(6'o63, 1'b0);
            8'h6C:   m = km(6'o64, 1'b0);
            8'h5A:   m = km(6'o53, 1'b0);
            8'h70:   m = km(6'o73, 1'b0);
            8'h71:   m = km(6'o74, 1'b0);
            default: m = '0;
         endcase
      end else begin
         case (code)
            8'h45:   m = km(6'o00, 1'b0);
            8'h16:   m = km(6'o01, 1'b0);
            8'h1E:   m = km(6'o02, 1'b0);
            8'h26:   m = km(6'o03, 1'b0);
            8'h25:   m = km(6'o04, 1'b0);
            8'h2E:   m = km(6'o05, 1'b0);
            8'h36:   m = km(6'o06, 1'b0);
            8'h3D:   m = km(6'o10, 1'b0);
            8'h3E:   m = km(6'o11, 1'b0);
            8'h46:   m = km(6'o12, 1'b0);
            8'h4C:   m = km(6'o13, 1'b1);
            8'h52:   m = km(6'o14, 1'b1);
            8'h4E:   m = km(6'o15, 1'b0);
            8'h41:   m = km(6'o16, 1'b0);
            8'h49:   m = km(6'o17, 1'b0);
            8'h1C:   m = km(6'o20, 1'b0);
            8'h32:   m = km(6'o21, 1'b0);
            8'h21:   m = km(6'o22, 1'b0);
            8'h23:   m = km(6'o23, 1'b0);
            8'h24:   m = km(6'o24, 1'b0);
            8'h2B:   m = km(6'o25, 1'b0);
            8'h34:   m = km(6'o26, 1'b0);
            8'h33:   m = km(6'o27, 1'b0);
            8'h43:   m = km(6'o30, 1'b0);
            8'h3B:   m = km(6'o31, 1'b0);
            8'h42:   m = km(6'o32, 1'b0);
            8'h4B:   m = km(6'o33, 1'b0);
            8'h3A:   m = km(6'o34, 1'b0);
            8'h31:   m = km(6'o35, 1'b0);
            8'h44:   m = km(6'o36, 1'b0);
            8'h4D:   m = km(6'o37, 1'b0);
            8'h15:   m = km(6'o40, 1'b0);
            8'h2D:   m = km(6'o41, 1'b0);
            8'h1B:   m = km(6'o42, 1'b0);
            8'h2C:   m = km(6'o43, 1'b0);
            8'h3C:   m = km(6'o44, 1'b0);
            8'h2A:   m = km(6'o45, 1'b0);
            8'h1D:   m = km(6'o46, 1'b0);
            8'h22:   m = km(6'o47, 1'b0);
            8'h35:   m = km(6'o50, 1'b0);
            8'h1A:   m = km(6'o51, 1'b0);
            8'h29:   m = km(6'o52, 1'b0);
            8'h5A:   m = km(6'o53, 1'b0);
            8'h66:   m = km(6'o54, 1'b0);
            8'h76:   m = km(6'o55, 1'b0);
            8'h4A:   m = km(6'o56, 1'b0);
            8'h0D:   m = km(6'o57, 1'b0);
            8'h05:   m = km(6'o65, 1'b0);
            8'h06:   m = km(6'o66, 1'b0);
            8'h04:   m = km(6'o67, 1'b0);
            8'h0C:   m = km(6'o70, 1'b0);
            8'h55:   m = km(6'o71, 1'b1);
            default: m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/kc87_kbd_fifo.sv
// Show-ahead event queue between ps2_key capture and the matrix FSM.
// A push on a full queue is accepted only when a pop frees a slot that cycle.
module kc87_kbd_fifo
   import kc87_kbd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  kbd_evt_t wdata,
   output kbd_evt_t rdata,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   kbd_evt_t        mem [DEPTH];
   logic [AW:0]     wp;
   logic [AW:0]     rp;
   logic            do_push;
   logic            do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) &&
                    (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/kc87_ps2_matrix.sv
// hps_io ps2_key events to KC87 8x8 matrix, with hold time and forced shift.
// KC87_KBD_GHOST_EN enables one-level matrix ghosting on the row read.
module kc87_ps2_matrix
   import kc87_kbd_pkg::*;
#(
   parameter int HOLD_CYCLES = 500000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [7:0]  col_sel_n,
   output logic [7:0]  row_n,
   output logic        kbd_busy,
   output logic        kbd_ovf
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   kbd_state_t       state;
   kbd_state_t       state_nxt;
   logic             toggle_q;
   logic             push;
   logic             full;
   logic             empty;
   kbd_evt_t         fifo_q;
   kbd_evt_t         evt_q;
   kbd_map_t         map_c;
   kbd_map_t         map_q;
   logic             is_shift;
   logic             noop;
   logic             pop_en;
   logic             dec_en;
   logic             apply_en;
   logic             hold_load;
   logic [CW-1:0]    hold_cnt;
   logic [7:0][7:0]  keys;
   logic [7:0][7:0]  mat;
   logic             pc_shl;
   logic             pc_shr;
   logic             fshift;
   logic [5:0]       fkey;
   logic [7:0]       sel_rows;
   logic [7:0]       rows;

   assign push = ps2_key[10] ^ toggle_q;

   kc87_kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop_en),
      .wdata (kbd_evt_t'(ps2_key[9:0])),
      .rdata (fifo_q),
      .full  (full),
      .empty (empty)
   );

   assign map_c    = kbd_lookup(evt_q.ext, evt_q.code);
   assign is_shift = !evt_q.ext &&
                     (evt_q.code == PS2_LSHIFT ||
                      evt_q.code == PS2_RSHIFT);
   assign noop     = (evt_q.pressed == keys[map_q.col][map_q.row]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!empty) state_nxt = S_POP;
         S_POP:    state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_shift)         state_nxt = S_HOLD;
            else if (map_c.valid) state_nxt = S_APPLY;
            else                  state_nxt = S_IDLE;
         end
         S_APPLY:  state_nxt = noop ? S_IDLE : S_HOLD;
         S_HOLD:   if (hold_cnt == '0) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pop_en    = (state == S_POP);
      dec_en    = (state == S_DECODE);
      apply_en  = (state == S_APPLY) && !noop;
      hold_load = (dec_en && is_shift) || apply_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_q <= 1'b0;
         kbd_ovf  <= 1'b0;
         evt_q    <= '0;
         map_q    <= '0;
         hold_cnt <= '0;
         keys     <= '0;
         pc_shl   <= 1'b0;
         pc_shr   <= 1'b0;
         fshift   <= 1'b0;
         fkey     <= '0;
      end else begin
         toggle_q <= ps2_key[10];
         if (push && full && !pop_en) kbd_ovf <= 1'b1;
         if (pop_en) evt_q <= fifo_q;
         if (dec_en) map_q <= map_c;
         if (dec_en && is_shift) begin
            if (evt_q.code == PS2_LSHIFT) pc_shl <= evt_q.pressed;
            else                          pc_shr <= evt_q.pressed;
         end
         if (hold_load)
            hold_cnt <= CW'(HOLD_CYCLES - 1);
         else if (state == S_HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
         if (apply_en) begin
            keys[map_q.col][map_q.row] <= evt_q.pressed;
            if (evt_q.pressed && map_q.shift_force) begin
               fshift <= 1'b1;
               fkey   <= {map_q.col, map_q.row};
            end
            if (!evt_q.pressed && fshift &&
                fkey == {map_q.col, map_q.row})
               fshift <= 1'b0;
         end
      end
   end

   // a forced-shift key inverts whatever shift the host is holding
   always_comb begin
      mat = keys;
      mat[KC_SHIFT_COL][KC_SHIFT_ROW] = (pc_shl | pc_shr) ^ fshift;
   end

`ifdef KC87_KBD_GHOST_EN
   logic [7:0] eff_cols;
`endif

   always_comb begin
      sel_rows = '0;
      for (int c = 0; c < 8; c++)
         if (!col_sel_n[c]) sel_rows = sel_rows | mat[c];
`ifdef KC87_KBD_GHOST_EN
      eff_cols = ~col_sel_n;
      for (int c = 0; c < 8; c++)
         if ((mat[c] & sel_rows) != '0) eff_cols[c] = 1'b1;
      rows = '0;
      for (int c = 0; c < 8; c++)
         if (eff_cols[c]) rows = rows | mat[c];
`else
      rows = sel_rows;
`endif
   end

   assign row_n    = ~rows;
   assign kbd_busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_kc87_ps2_matrix.sv
// Scoreboard bench for kc87_ps2_matrix (HOLD_CYCLES=16, FIFO_DEPTH=4).
// Expected row_n values are queued at stimulus time and checked on change.
module tb_kc87_ps2_matrix;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [7:0]  col_sel_n;
   logic [7:0]  row_n;
   logic        kbd_busy;
   logic        kbd_ovf;

   int          n_vec = 0;
   int          n_err = 0;
   logic        tog = 1'b0;
   logic        mon_en = 1'b0;
   logic [7:0]  last_row = 8'hFF;
   logic [7:0]  exp_q [$];

`ifdef KC87_KBD_GHOST_EN
   localparam logic [7:0] GHOST_EXP = 8'hFC;
`else
   localparam logic [7:0] GHOST_EXP = 8'hFE;
`endif

   kc87_ps2_matrix #(.HOLD_CYCLES(16), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_key   (ps2_key),
      .col_sel_n (col_sel_n),
      .row_n     (row_n),
      .kbd_busy  (kbd_busy),
      .kbd_ovf   (kbd_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && row_n !== last_row) begin
         if (exp_q.size() == 0) chk("sb_extra", row_n, last_row);
         else                   chk("sb_row", row_n, exp_q.pop_front());
      end
      last_row = row_n;
   end

   task automatic send(input logic pr, input logic ex,
                       input logic [7:0] code);
      @(negedge clk);
      tog = ~tog;
      ps2_key = {tog, pr, ex, code};
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      @(negedge clk);
      while (kbd_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 8'(kbd_busy), 8'h00);
   endtask

   task automatic sel_cols(input logic [7:0] sel_n, input logic mon);
      mon_en = 1'b0;
      col_sel_n = sel_n;
      repeat (2) @(negedge clk);
      mon_en = mon;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int low;
      int hi_busy;
      int bad;
      logic [7:0] rel_code [5];
      logic [7:0] rel_exp  [5];
      logic [7:0] prs_code [6];
      logic [7:0] prs_exp  [5];
      prs_code = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
      prs_exp  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0};
      rel_code = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
      rel_exp  = '{8'hE1, 8'hE3, 8'hE7, 8'hEF, 8'hFF};

      reset = 1'b1;
      ps2_key = '0;
      col_sel_n = 8'hFF;
      repeat (2) @(negedge clk);
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
      @(negedge clk);
      ps2_key[10] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_row", row_n, 8'hFF);
      chk("rst_busy", 8'(kbd_busy), 8'h00);
      chk("rst_ovf", 8'(kbd_ovf), 8'h00);
      sel_cols(~8'h04, 1'b1);
      chk("rst_col2", row_n, 8'hFF);

      // single press: 4 clocks from the capturing edge
      exp_q.push_back(8'hFE);
      send(1'b1, 1'b0, 8'h1C);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1 chk("lat3", row_n, 8'hFF);
      @(posedge clk);
      #1 chk("lat4", row_n, 8'hFE);
      wait_idle("t2_idle_p", n);
      exp_q.push_back(8'hFF);
      send(1'b0, 1'b0, 8'h1C);
      wait_idle("t2_idle_r", n);
      chk("t2_row", row_n, 8'hFF);
      chk("t2_drain", 8'(exp_q.size()), 8'h00);

      // press and release on consecutive cycles
      sel_cols(~8'h04, 1'b0);
      send(1'b1, 1'b0, 8'h1C);
      send(1'b0, 1'b0, 8'h1C);
      low = 0;
      hi_busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!kbd_busy) break;
         if (!row_n[0]) low++;
         else if (low > 0) hi_busy++;
      end
      chk("t3_low16", 8'(low >= 16), 8'h01);
      chk("t3_busyhold", 8'(hi_busy >= 16), 8'h01);
      chk("t3_end", 8'(kbd_busy), 8'h00);
      chk("t3_row", row_n, 8'hFF);

      // six back-to-back events into a depth-4 queue
      sel_cols(~8'h04, 1'b1);
      for (int i = 0; i < 5; i++) exp_q.push_back(prs_exp[i]);
      for (int i = 0; i < 6; i++) send(1'b1, 1'b0, prs_code[i]);
      wait_idle("t4_idle", n);
      chk("t4_drain", 8'(exp_q.size()), 8'h00);
      chk("t4_row", row_n, 8'hE0);
      chk("t4_ovf", 8'(kbd_ovf), 8'h01);
      send(1'b0, 1'b0, 8'h2B);
      wait_idle("t4_noop_idle", n);
      chk("t4_noop_fast", 8'(n < 8), 8'h01);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(rel_exp[i]);
         send(1'b0, 1'b0, rel_code[i]);
         wait_idle("t4_rel_idle", n);
      end
      chk("t4_rel_drain", 8'(exp_q.size()), 8'h00);

      // host shift plus a forced-shift key
      sel_cols(~8'h01, 1'b1);
      exp_q.push_back(8'h7F);
      send(1'b1, 1'b0, 8'h12);
      wait_idle("t5_idle", n);
      exp_q.push_back(8'hFF);
      send(1'b1, 1'b0, 8'h4C);
      wait_idle("t5_idle", n);
      sel_cols(~8'h02, 1'b0);
      chk("t5_colon_key", row_n, 8'hF7);
      sel_cols(~8'h01, 1'b1);
      exp_q.push_back(8'h7F);
      send(1'b0, 1'b0, 8'h4C);
      wait_idle("t5_idle", n);
      exp_q.push_back(8'hFF);
      send(1'b0, 1'b0, 8'h12);
      wait_idle("t5_idle", n);
      chk("t5_drain", 8'(exp_q.size()), 8'h00);

      // reset in the middle of HOLD with events still queued
      sel_cols(~8'h04, 1'b0);
      chk("t6_ovf_sticky", 8'(kbd_ovf), 8'h01);
      send(1'b1, 1'b0, 8'h1C);
      send(1'b1, 1'b0, 8'h32);
      send(1'b1, 1'b0, 8'h21);
      repeat (8) @(negedge clk);
      chk("t6_pre_row", row_n, 8'hFE);
      chk("t6_pre_busy", 8'(kbd_busy), 8'h01);
      reset = 1'b1;
      tog = 1'b0;
      ps2_key[10] = 1'b0;
      @(negedge clk);
      chk("t6_rst_row", row_n, 8'hFF);
      chk("t6_rst_busy", 8'(kbd_busy), 8'h00);
      @(negedge clk);
      reset = 1'b0;
      col_sel_n = 8'h00;
      bad = 0;
      repeat (24) begin
         @(negedge clk);
         if (row_n !== 8'hFF || kbd_busy !== 1'b0) bad++;
      end
      chk("t6_quiet", 8'(bad), 8'h00);
      chk("t6_ovf_clr", 8'(kbd_ovf), 8'h00);

      // ghosting over (c0,r0) (c1,r0) (c1,r1)
      sel_cols(~8'h01, 1'b0);
      send(1'b1, 1'b0, 8'h45);
      wait_idle("t7_idle", n);
      send(1'b1, 1'b0, 8'h3D);
      wait_idle("t7_idle", n);
      send(1'b1, 1'b0, 8'h3E);
      wait_idle("t7_idle", n);
      chk("t7_ghost_c0", row_n, GHOST_EXP);
      sel_cols(~8'h03, 1'b0);
      chk("t7_c0c1", row_n, 8'hFC);
      sel_cols(8'hFF, 1'b0);
      chk("t7_none", row_n, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
